// File: rtl/mbed_tester_pkg.sv
// Shared constants and the APB address-region decoder for the pin router slave.
package mbed_tester_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [DATA_BITS-1:0] SEL_NONE     = 8'd0;
    localparam logic [DATA_BITS-1:0] SEL_GPIO     = 8'd1;
    localparam logic [DATA_BITS-1:0] SEL_EXT_BASE = 8'd2;

    localparam logic [11:0] REG_GLOBAL_SEL = 12'h000;
    localparam logic [11:0] REG_PIN_SEL    = 12'h100;
    localparam logic [11:0] REG_GPIO       = 12'h200;
    localparam logic [11:0] REG_EDGE_CNT   = 12'h300;
    localparam logic [11:0] REG_CTRL       = 12'h400;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_GLOBAL,
        RGN_PIN_SEL,
        RGN_GPIO,
        RGN_EDGE_CNT,
        RGN_CTRL
    } region_t;

    // Per-pin regions only decode when the low byte names an existing pin.
    function automatic region_t decode_region(input logic [11:0] addr, input int n_pins);
        region_t r;
        r = RGN_NONE;
        if (addr == REG_GLOBAL_SEL) begin
            r = RGN_GLOBAL;
        end else if (addr == REG_CTRL) begin
            r = RGN_CTRL;
        end else if ({24'd0, addr[7:0]} < n_pins) begin
            if (addr[11:8] == REG_PIN_SEL[11:8]) begin
                r = RGN_PIN_SEL;
            end else if (addr[11:8] == REG_GPIO[11:8]) begin
                r = RGN_GPIO;
            end else if (addr[11:8] == REG_EDGE_CNT[11:8]) begin
                r = RGN_EDGE_CNT;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pin_edge_counter.sv
// Per-pin input synchroniser, rising-edge detector and saturating 8-bit edge counter.
module pin_edge_counter
    import mbed_tester_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pin_in,
    input  logic                 enable,
    input  logic                 clear,
    output logic                 synced,
    output logic [DATA_BITS-1:0] count
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic [DATA_BITS-1:0]   count_reg;
    logic                   rise;

    assign synced = sync_reg[SYNC_STAGES-1];
    assign rise   = synced & ~prev_reg;
    assign count  = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin_in};
            prev_reg <= synced;
            // A clear in the same cycle as an edge discards that edge.
            if (clear) begin
                count_reg <= '0;
            end else if (enable && rise && (count_reg != '1)) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbed_tester_pin_router_apb2_slave.sv
// APB2 slave routing each logical pin to none, GPIO or one of the external testers,
// with a GPIO bank and per-pin rising-edge counters.
module mbed_tester_pin_router_apb2_slave
    import mbed_tester_pkg::*;
#(
    parameter int IO_LOGICAL      = 8,
    parameter int EXT_PERIPHERALS = 5,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [IO_LOGICAL-1:0]                 logical_in,
    output logic [IO_LOGICAL-1:0]                 logical_val,
    output logic [IO_LOGICAL-1:0]                 logical_drive,
    input  logic [EXT_PERIPHERALS*IO_LOGICAL-1:0] ext_val,
    input  logic [EXT_PERIPHERALS*IO_LOGICAL-1:0] ext_drive,
    input  logic [11:0]                           PADDR,
    input  logic                                  PSEL,
    input  logic                                  PENABLE,
    input  logic                                  PWRITE,
    input  logic [DATA_BITS-1:0]                  PWDATA,
    output logic [DATA_BITS-1:0]                  PRDATA
);

    region_t              region;
    logic [7:0]           idx;
    logic                 wr_en;
    logic                 rd_en;

    logic [DATA_BITS-1:0] global_sel_reg;
    logic [DATA_BITS-1:0] sel_reg [IO_LOGICAL];
    logic [IO_LOGICAL-1:0] gpio_val_reg;
    logic [IO_LOGICAL-1:0] gpio_drive_reg;
    logic                 cnt_en_reg;
    logic [DATA_BITS-1:0] prdata_reg;
    logic [DATA_BITS-1:0] rd_data;
    logic [IO_LOGICAL-1:0] val_reg;
    logic [IO_LOGICAL-1:0] drive_reg;
    logic [IO_LOGICAL-1:0] val_next;
    logic [IO_LOGICAL-1:0] drive_next;

    logic [IO_LOGICAL-1:0] synced;
    logic [IO_LOGICAL-1:0] cnt_clear;
    logic [DATA_BITS-1:0] count    [IO_LOGICAL];
    logic [DATA_BITS-1:0] rd_chain [IO_LOGICAL+1];

    assign region = decode_region(PADDR, IO_LOGICAL);
    assign idx    = PADDR[7:0];
    assign wr_en  = PSEL & PWRITE & PENABLE;
    assign rd_en  = PSEL & ~PWRITE;

    assign rd_chain[0] = '0;

    genvar gi, gk;
    generate
        for (gi = 0; gi < IO_LOGICAL; gi++) begin : g_pin
            logic                       pin_hit;
            logic [DATA_BITS-1:0]       pin_rd;
            logic [EXT_PERIPHERALS-1:0] ext_hit;
            logic [EXT_PERIPHERALS-1:0] ext_v;
            logic [EXT_PERIPHERALS-1:0] ext_d;
            logic                       gpio_hit;

            assign pin_hit = (idx == 8'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_reg[gi]        <= SEL_NONE;
                    gpio_val_reg[gi]   <= 1'b0;
                    gpio_drive_reg[gi] <= 1'b0;
                end else if (wr_en) begin
                    if (region == RGN_GLOBAL) begin
                        sel_reg[gi] <= PWDATA;
                    end else if (region == RGN_PIN_SEL && pin_hit) begin
                        sel_reg[gi] <= PWDATA;
                    end else if (region == RGN_GPIO && pin_hit) begin
                        gpio_val_reg[gi]   <= PWDATA[0];
                        gpio_drive_reg[gi] <= PWDATA[1];
                    end
                end
            end

            // Selects past the last external peripheral match nothing and stay undriven.
            for (gk = 0; gk < EXT_PERIPHERALS; gk++) begin : g_ext
                assign ext_hit[gk] = (sel_reg[gi] == SEL_EXT_BASE + 8'(gk));
                assign ext_v[gk]   = ext_val[gk*IO_LOGICAL + gi];
                assign ext_d[gk]   = ext_drive[gk*IO_LOGICAL + gi];
            end

            assign gpio_hit       = (sel_reg[gi] == SEL_GPIO);
            assign val_next[gi]   = (gpio_hit & gpio_val_reg[gi]) | (|(ext_hit & ext_v));
            assign drive_next[gi] = (gpio_hit & gpio_drive_reg[gi]) | (|(ext_hit & ext_d));
            assign cnt_clear[gi]  = wr_en && (region == RGN_EDGE_CNT) && pin_hit;

            pin_edge_counter #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .pin_in(logical_in[gi]),
                .enable(cnt_en_reg),
                .clear (cnt_clear[gi]),
                .synced(synced[gi]),
                .count (count[gi])
            );

            always_comb begin
                pin_rd = '0;
                if (pin_hit) begin
                    case (region)
                        RGN_PIN_SEL:  pin_rd = sel_reg[gi];
                        RGN_GPIO:     pin_rd = {{(DATA_BITS-3){1'b0}}, gpio_val_reg[gi],
                                                gpio_drive_reg[gi], synced[gi]};
                        RGN_EDGE_CNT: pin_rd = count[gi];
                        default:      pin_rd = '0;
                    endcase
                end
            end

            assign rd_chain[gi+1] = rd_chain[gi] | pin_rd;
        end
    endgenerate

    always_comb begin
        rd_data = rd_chain[IO_LOGICAL];
        if (region == RGN_GLOBAL) begin
            rd_data = global_sel_reg;
        end else if (region == RGN_CTRL) begin
            rd_data = {{(DATA_BITS-1){1'b0}}, cnt_en_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            global_sel_reg <= SEL_NONE;
            cnt_en_reg     <= 1'b0;
            prdata_reg     <= '0;
            val_reg        <= '0;
            drive_reg      <= '0;
        end else begin
            if (wr_en && region == RGN_GLOBAL) begin
                global_sel_reg <= PWDATA;
            end
            if (wr_en && region == RGN_CTRL) begin
                cnt_en_reg <= PWDATA[0];
            end
            if (rd_en) begin
                prdata_reg <= rd_data;
            end
            val_reg   <= val_next;
            drive_reg <= drive_next;
        end
    end

    assign logical_val   = val_reg;
    assign logical_drive = drive_reg;
    assign PRDATA        = prdata_reg;

endmodule
